// File: rtl/phase_sweep_ctrl.sv
// Phase sweep sequencer: resets, settles and measures the DSP chain at every sampling phase,
// keeps the lowest-error phase and leaves the chain running there when the sweep ends.
module phase_sweep_ctrl #(
  parameter int unsigned NbCount      = 64,
  parameter int unsigned NbPhase      = 2,
  parameter int unsigned RstCycles    = 16,
  parameter int unsigned SettleCycles = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [31:0]                 window_i,
  input  logic [31:0]                 timeout_i,
  input  logic [NbCount-1:0]          error_count_r_i,
  input  logic [NbCount-1:0]          error_count_i_i,
  input  logic [NbCount-1:0]          bit_count_r_i,
  output logic                        dsp_rst_o,
  output logic [2:0]                  enable_o,
  output logic [NbPhase-1:0]          phase_o,
  output logic [NbPhase-1:0]          best_phase_o,
  output logic [NbCount-1:0]          best_errors_o,
  output logic [(2**NbPhase)-1:0]     timeout_flags_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned NumPhases = 2 ** NbPhase;

  typedef enum logic [2:0] {StIdle, StRst, StSettle, StMeasure, StEval} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [NbPhase-1:0]     p_q, p_d;
  logic [NbCount-1:0]     best_q, best_d;
  logic [NbPhase-1:0]     best_phase_q, best_phase_d;
  logic [NumPhases-1:0]   flags_q, flags_d;
  logic [2:0]             enable_q, enable_d;
  logic                   dsp_rst_q, dsp_rst_d;
  logic [NbPhase-1:0]     phase_out_q, phase_out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   sweep_end, abort_hit, advance;
  logic                   window_met, timeout_hit, p_last;
  logic [NbCount:0]       err_sum;
  logic [NbCount-1:0]     err_sat;

  assign err_sum     = {1'b0, error_count_r_i} + {1'b0, error_count_i_i};
  assign err_sat     = err_sum[NbCount] ? '1 : err_sum[NbCount-1:0];
  assign window_met  = bit_count_r_i >= NbCount'(window_i);
  assign timeout_hit = (timeout_i != 32'd0) && (cnt_q == timeout_i - 32'd1);
  assign p_last      = (p_q == NbPhase'(NumPhases - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      p_q          <= '0;
      best_q       <= '1;
      best_phase_q <= '0;
      flags_q      <= '0;
      enable_q     <= 3'b000;
      dsp_rst_q    <= 1'b0;
      phase_out_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      p_q          <= p_d;
      best_q       <= best_d;
      best_phase_q <= best_phase_d;
      flags_q      <= flags_d;
      enable_q     <= enable_d;
      dsp_rst_q    <= dsp_rst_d;
      phase_out_q  <= phase_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state and sweep bookkeeping
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    p_d          = p_q;
    best_d       = best_q;
    best_phase_d = best_phase_q;
    flags_d      = flags_q;
    sweep_end    = 1'b0;
    abort_hit    = 1'b0;
    advance      = 1'b0;
    if (abort_i) begin
      // Abort overrides every transition, including a start in IDLE.
      abort_hit = 1'b1;
      state_d   = StIdle;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d      = StRst;
            cnt_d        = '0;
            p_d          = '0;
            best_d       = '1;
            best_phase_d = '0;
            flags_d      = '0;
          end
        end
        StRst: begin
          if (cnt_q == 32'(RstCycles - 1)) begin
            state_d = StSettle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StSettle: begin
          if (cnt_q == 32'(SettleCycles - 1)) begin
            state_d = StMeasure;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StMeasure: begin
          if (window_met) begin
            state_d = StEval;
            cnt_d   = '0;
          end else if (timeout_hit) begin
            flags_d[p_q] = 1'b1;
            advance      = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StEval: begin
          // Strict compare so ties keep the lower phase.
          if (err_sat < best_q) begin
            best_d       = err_sat;
            best_phase_d = p_q;
          end
          advance = 1'b1;
        end
        default: state_d = StIdle;
      endcase
      if (advance) begin
        cnt_d = '0;
        if (p_last) begin
          state_d   = StIdle;
          sweep_end = 1'b1;
        end else begin
          p_d     = p_q + 1'b1;
          state_d = StRst;
        end
      end
    end
  end

  // Registered DSP controls follow the state being entered; IDLE holds them.
  always_comb begin
    enable_d    = enable_q;
    dsp_rst_d   = dsp_rst_q;
    phase_out_d = phase_out_q;
    busy_d      = busy_q;
    done_d      = done_q;
    unique case (state_d)
      StRst: begin
        dsp_rst_d   = 1'b1;
        enable_d    = 3'b000;
        phase_out_d = p_d;
        busy_d      = 1'b1;
        done_d      = 1'b0;
      end
      StSettle: begin
        dsp_rst_d = 1'b0;
        enable_d  = 3'b011;
      end
      StMeasure: begin
        dsp_rst_d = 1'b0;
        enable_d  = 3'b111;
      end
      StEval: begin
        dsp_rst_d = 1'b0;
        enable_d  = 3'b011;
      end
      default: begin
        if (abort_hit) begin
          done_d = 1'b0;
          if (state_q != StIdle) begin
            enable_d  = 3'b000;
            dsp_rst_d = 1'b0;
            busy_d    = 1'b0;
          end
        end else if (sweep_end) begin
          enable_d    = 3'b011;
          dsp_rst_d   = 1'b0;
          phase_out_d = best_phase_d;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end
      end
    endcase
  end

  assign dsp_rst_o       = dsp_rst_q;
  assign enable_o        = enable_q;
  assign phase_o         = phase_out_q;
  assign best_phase_o    = best_phase_q;
  assign best_errors_o   = best_q;
  assign timeout_flags_o = flags_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule
